// File: rtl/pc_fetch_unit.sv
// Two-state instruction fetch / PC sequencer: fetches one word, presents it to
// the decoder, then updates pc (sequential, jump, or Z/N-conditional branch).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   FETCH | imem_req high at pc, waiting for imem_ack to load inst
//   EXEC  | inst valid to decoder; on stall=0 update pc, retire, refetch
module pc_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst,
    output logic        inst_valid,
    input  logic        pl,
    input  logic        jb,
    input  logic        bc,
    input  logic        z_flag,
    input  logic        n_flag,
    input  logic [15:0] ra_data,
    input  logic        stall,
    output logic [15:0] pc,
    output logic [15:0] retired
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc_nxt;
    logic [15:0] inst_nxt;
    logic [15:0] retired_nxt;
    logic [15:0] branch_ofs;
    logic        branch_cond;

    // 6-bit signed offset split across inst[8:6] and inst[2:0], relative to this pc
    assign branch_ofs  = {{10{inst[8]}}, inst[8:6], inst[2:0]};
    assign branch_cond = bc ? n_flag : z_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= 16'h0000;
            inst    <= 16'h0000;
            retired <= 16'h0000;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            inst    <= inst_nxt;
            retired <= retired_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        inst_nxt    = inst;
        retired_nxt = retired;
        imem_req    = 1'b0;
        inst_valid  = 1'b0;

        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    inst_nxt  = imem_rdata;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (!stall) begin
                    if (pl && jb)
                        pc_nxt = ra_data;
                    else if (pl && branch_cond)
                        pc_nxt = pc + branch_ofs;
                    else
                        pc_nxt = pc + 16'd1;
                    retired_nxt = retired + 16'd1;
                    state_nxt   = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, wait states, jump,
// branches with wrap, stall hold, and reset in both states.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] inst;
    logic        inst_valid;
    logic        pl, jb, bc, z_flag, n_flag;
    logic [15:0] ra_data;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_ret = 16'd0;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pl         (pl),
        .jb         (jb),
        .bc         (bc),
        .z_flag     (z_flag),
        .n_flag     (n_flag),
        .ra_data    (ra_data),
        .stall      (stall),
        .pc         (pc),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch at exp_pc, then confirm EXEC with the loaded word.
    task automatic do_fetch(input string tag, input logic [15:0] exp_pc, input logic [15:0] word);
        chk({tag, "_req"}, {15'd0, imem_req}, 16'd1);
        chk({tag, "_addr"}, imem_addr, exp_pc);
        chk({tag, "_valid0"}, {15'd0, inst_valid}, 16'd0);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        chk({tag, "_valid1"}, {15'd0, inst_valid}, 16'd1);
        chk({tag, "_req0"}, {15'd0, imem_req}, 16'd0);
        chk({tag, "_inst"}, inst, word);
    endtask

    task automatic do_exec(input string tag, input logic i_pl, input logic i_jb, input logic i_bc,
                           input logic i_z, input logic i_n, input logic [15:0] i_ra,
                           input logic [15:0] exp_pc);
        pl = i_pl; jb = i_jb; bc = i_bc; z_flag = i_z; n_flag = i_n; ra_data = i_ra;
        stall = 1'b0;
        tick();
        exp_ret = exp_ret + 16'd1;
        pl = 1'b0; jb = 1'b0; bc = 1'b0; z_flag = 1'b0; n_flag = 1'b0;
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_ret"}, retired, exp_ret);
        chk({tag, "_valid"}, {15'd0, inst_valid}, 16'd0);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000;
        pl = 1'b0; jb = 1'b0; bc = 1'b0; z_flag = 1'b0; n_flag = 1'b0;
        ra_data = 16'h0000; stall = 1'b0;

        tick();
        tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_ret", retired, 16'h0000);
        chk("rst_valid", {15'd0, inst_valid}, 16'd0);
        rst = 1'b0;
        chk("rst_req", {15'd0, imem_req}, 16'd1);

        // Sequential, zero-wait: 2 cycles per instruction
        do_fetch("seq0", 16'h0000, 16'h1000);
        do_exec ("seq0x", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001);
        do_fetch("seq1", 16'h0001, 16'h1001);
        do_exec ("seq1x", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002);
        do_fetch("seq2", 16'h0002, 16'h1002);
        do_exec ("seq2x", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003);
        chk("seq_ret3", retired, 16'd3);
        chk("seq_addr3", imem_addr, 16'h0003);

        // Wait states: ack delayed 3 cycles
        imem_rdata = 16'hABCD;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_req", {15'd0, imem_req}, 16'd1);
            chk("ws_addr", imem_addr, 16'h0003);
            chk("ws_inst_hold", inst, 16'h1002);
            chk("ws_valid", {15'd0, inst_valid}, 16'd0);
        end
        do_fetch("ws", 16'h0003, 16'hABCD);

        // ack in EXEC ignored
        imem_ack = 1'b1; imem_rdata = 16'h5555; stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("exec_ack_ign", inst, 16'hABCD);
        chk("exec_ack_valid", {15'd0, inst_valid}, 16'd1);
        do_exec("jmp10", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0010);

        // Stall 5 cycles at pc=0x0010, ra_data changing, release with jump
        do_fetch("stl", 16'h0010, 16'h7777);
        stall = 1'b1; pl = 1'b1; jb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ra_data = 16'h1100 + 16'(i);
            tick();
            chk("stl_valid", {15'd0, inst_valid}, 16'd1);
            chk("stl_pc", pc, 16'h0010);
            chk("stl_inst", inst, 16'h7777);
            chk("stl_ret", retired, exp_ret);
        end
        do_exec("jmp1234", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1234);
        chk("jmp_addr", imem_addr, 16'h1234);

        // Branches with offset -4 from pc=2
        do_fetch("j2", 16'h1234, 16'h0000);
        do_exec ("j2x", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0002);
        do_fetch("bz1", 16'h0002, 16'h01C4);
        do_exec ("bz1x", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFE);
        do_fetch("j2b", 16'hFFFE, 16'h0000);
        do_exec ("j2bx", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0002);
        do_fetch("bz0", 16'h0002, 16'h01C4);
        do_exec ("bz0x", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003);
        do_fetch("bn1", 16'h0003, 16'h01C4);
        do_exec ("bn1x", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF);

        // Wrap from 0xFFFF, then self-branch, then +31
        do_fetch("wrap", 16'hFFFF, 16'h0000);
        do_exec ("wrapx", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        do_fetch("self", 16'h0000, 16'h0000);
        do_exec ("selfx", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        do_fetch("p31", 16'h0000, 16'h00C7);
        do_exec ("p31x", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h001F);

        // Reset during fetch at pc=5 with ack asserted
        do_fetch("j5", 16'h001F, 16'h0000);
        do_exec ("j5x", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0005);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        tick();
        rst = 1'b0; imem_ack = 1'b0;
        exp_ret = 16'd0;
        chk("rf_pc", pc, 16'h0000);
        chk("rf_inst", inst, 16'h0000);
        chk("rf_ret", retired, 16'h0000);
        chk("rf_valid", {15'd0, inst_valid}, 16'd0);
        chk("rf_req", {15'd0, imem_req}, 16'd1);
        chk("rf_addr", imem_addr, 16'h0000);

        // Reset in EXEC: no pc update or retire
        do_fetch("re", 16'h0000, 16'h2222);
        rst = 1'b1; stall = 1'b0; pl = 1'b1; jb = 1'b1; ra_data = 16'h4444;
        tick();
        rst = 1'b0; pl = 1'b0; jb = 1'b0;
        chk("re_valid", {15'd0, inst_valid}, 16'd0);
        chk("re_pc", pc, 16'h0000);
        chk("re_ret", retired, 16'h0000);
        chk("re_inst", inst, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
